// File: rtl/flood_reveal.sv
// flood_reveal: reveal/flag controller for an 8x8 mine board.
// A reveal of a safe hidden cell is expanded with a LIFO flood fill. Each
// popped cell with zero adjacent mines is expanded over its 8 neighbours,
// one neighbour per cycle, in a fixed order.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a command (cmd_ready = 1)
// POP       | pop and reveal top of stack; with an empty stack, finish
// EXPAND    | visit neighbour slot_q of cur_q, push it if eligible
// LOST      | a mine was revealed; terminal until reset
// WON       | every safe cell is revealed; terminal until reset
module flood_reveal (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        flag,
    input  logic [2:0]  pos_x,
    input  logic [2:0]  pos_y,
    input  logic [63:0] mine_map,
    output logic [63:0] revealed,
    output logic [63:0] flagged,
    output logic        busy,
    output logic        done,
    output logic        lost,
    output logic        won,
    output logic [6:0]  reveal_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_EXPAND = 3'd2;
    localparam logic [2:0] ST_LOST   = 3'd3;
    localparam logic [2:0] ST_WON    = 3'd4;

    // Neighbour of idx in slot order; returns {in_bounds, ny, nx}.
    // Offsets are added as 4-bit values (4'hF = -1), so both x=0,dx=-1 and
    // x=7,dx=+1 land with bit 3 set, which marks the neighbour off-board.
    function automatic logic [6:0] nbr_of(input logic [5:0] idx, input logic [2:0] slot);
        logic [3:0] dx;
        logic [3:0] dy;
        logic [3:0] nx;
        logic [3:0] ny;
        dx = 4'h0;
        dy = 4'h0;
        case (slot)
            3'd0: begin dy = 4'hF; dx = 4'hF; end
            3'd1: begin dy = 4'hF; dx = 4'h0; end
            3'd2: begin dy = 4'hF; dx = 4'h1; end
            3'd3: begin dy = 4'h0; dx = 4'hF; end
            3'd4: begin dy = 4'h0; dx = 4'h1; end
            3'd5: begin dy = 4'h1; dx = 4'hF; end
            3'd6: begin dy = 4'h1; dx = 4'h0; end
            3'd7: begin dy = 4'h1; dx = 4'h1; end
            default: begin dy = 4'h0; dx = 4'h0; end
        endcase
        nx = {1'b0, idx[2:0]} + dx;
        ny = {1'b0, idx[5:3]} + dy;
        return {~(nx[3] | ny[3]), ny[2:0], nx[2:0]};
    endfunction

    logic [2:0]  state_q, state_d;
    logic [63:0] revealed_q, revealed_d;
    logic [63:0] flagged_q, flagged_d;
    logic [63:0] queued_q, queued_d;
    logic [6:0]  sp_q, sp_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [5:0]  cur_q, cur_d;
    logic [2:0]  slot_q, slot_d;
    logic        done_q, done_d;
    logic        lost_q, lost_d;
    logic        won_q, won_d;

    logic [5:0]  stack_mem [64];
    logic        push_en;
    logic [5:0]  push_idx;

    logic [5:0]  top_idx;
    logic [3:0]  adj_cnt;
    logic [6:0]  adj_nbr;
    logic [6:0]  exp_nbr;
    logic [5:0]  exp_idx;
    logic        exp_push;
    logic [5:0]  cmd_idx;
    logic [6:0]  mine_cnt;
    logic [6:0]  safe_cnt;

    assign top_idx  = stack_mem[sp_q[5:0] - 6'd1];
    assign cmd_idx  = {pos_y, pos_x};
    assign mine_cnt = 7'($countones(mine_map));
    assign safe_cnt = 7'd64 - mine_cnt;

    // Adjacent-mine count of the cell about to be popped.
    always_comb begin
        adj_cnt = 4'd0;
        adj_nbr = 7'd0;
        for (int s = 0; s < 8; s++) begin
            adj_nbr = nbr_of(top_idx, 3'(s));
            if (adj_nbr[6] && mine_map[adj_nbr[5:0]]) begin
                adj_cnt = adj_cnt + 4'd1;
            end
        end
    end

    // Eligibility of the neighbour visited in the current EXPAND slot.
    always_comb begin
        exp_nbr  = nbr_of(cur_q, slot_q);
        exp_idx  = exp_nbr[5:0];
        exp_push = exp_nbr[6] && !revealed_q[exp_idx] && !flagged_q[exp_idx]
                   && !mine_map[exp_idx] && !queued_q[exp_idx];
    end

    // Next-state logic for the command handler and flood fill.
    always_comb begin
        state_d    = state_q;
        revealed_d = revealed_q;
        flagged_d  = flagged_q;
        queued_d   = queued_q;
        sp_d       = sp_q;
        cnt_d      = cnt_q;
        cur_d      = cur_q;
        slot_d     = slot_q;
        done_d     = 1'b0;
        lost_d     = lost_q;
        won_d      = won_q;
        push_en    = 1'b0;
        push_idx   = 6'd0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (flag) begin
                        if (!revealed_q[cmd_idx]) begin
                            flagged_d[cmd_idx] = ~flagged_q[cmd_idx];
                        end
                        done_d = 1'b1;
                    end else if (flagged_q[cmd_idx] || revealed_q[cmd_idx]) begin
                        done_d = 1'b1;
                    end else if (mine_map[cmd_idx]) begin
                        revealed_d[cmd_idx] = 1'b1;
                        lost_d              = 1'b1;
                        done_d              = 1'b1;
                        state_d             = ST_LOST;
                    end else begin
                        push_en           = 1'b1;
                        push_idx          = cmd_idx;
                        sp_d              = sp_q + 7'd1;
                        queued_d[cmd_idx] = 1'b1;
                        state_d           = ST_POP;
                    end
                end
            end

            ST_POP: begin
                if (sp_q != 7'd0) begin
                    revealed_d[top_idx] = 1'b1;
                    cnt_d               = cnt_q + 7'd1;
                    sp_d                = sp_q - 7'd1;
                    cur_d               = top_idx;
                    if (adj_cnt == 4'd0) begin
                        slot_d  = 3'd0;
                        state_d = ST_EXPAND;
                    end
                end else begin
                    // Empty stack in POP is the finish cycle.
                    queued_d = 64'd0;
                    done_d   = 1'b1;
                    if (cnt_q == safe_cnt) begin
                        won_d   = 1'b1;
                        state_d = ST_WON;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_EXPAND: begin
                if (exp_push) begin
                    push_en           = 1'b1;
                    push_idx          = exp_idx;
                    sp_d              = sp_q + 7'd1;
                    queued_d[exp_idx] = 1'b1;
                end
                slot_d = slot_q + 3'd1;
                // POP with an empty stack finishes, so always return there.
                if (slot_q == 3'd7) begin
                    state_d = ST_POP;
                end
            end

            ST_LOST, ST_WON: begin
                state_d = state_q;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and board state registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            revealed_q <= 64'd0;
            flagged_q  <= 64'd0;
            queued_q   <= 64'd0;
            sp_q       <= 7'd0;
            cnt_q      <= 7'd0;
            cur_q      <= 6'd0;
            slot_q     <= 3'd0;
            done_q     <= 1'b0;
            lost_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            revealed_q <= revealed_d;
            flagged_q  <= flagged_d;
            queued_q   <= queued_d;
            sp_q       <= sp_d;
            cnt_q      <= cnt_d;
            cur_q      <= cur_d;
            slot_q     <= slot_d;
            done_q     <= done_d;
            lost_q     <= lost_d;
            won_q      <= won_d;
        end
    end

    // LIFO storage; contents are meaningless once sp_q is cleared.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp_q[5:0]] <= push_idx;
        end
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_POP) || (state_q == ST_EXPAND);
    assign done       = done_q;
    assign lost       = lost_q;
    assign won        = won_q;
    assign revealed   = revealed_q;
    assign flagged    = flagged_q;
    assign reveal_cnt = cnt_q;

endmodule

// File: tb/tb_flood_reveal.sv
// Scoreboard bench for flood_reveal: each issued command pushes its expected
// completion state; a monitor pops and compares on every done pulse.
module tb_flood_reveal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        flag = 1'b0;
    logic [2:0]  pos_x = 3'd0;
    logic [2:0]  pos_y = 3'd0;
    logic [63:0] mine_map = 64'd0;
    logic [63:0] revealed;
    logic [63:0] flagged;
    logic        busy;
    logic        done;
    logic        lost;
    logic        won;
    logic [6:0]  reveal_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] rev;
        logic [63:0] flg;
        logic [6:0]  cnt;
        logic        lst;
        logic        wn;
        logic        rdy;
        int          lat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    flood_reveal dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .flag       (flag),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .mine_map   (mine_map),
        .revealed   (revealed),
        .flagged    (flagged),
        .busy       (busy),
        .done       (done),
        .lost       (lost),
        .won        (won),
        .reveal_cnt (reveal_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] rev, input logic [63:0] flg,
                                input logic [6:0] cnt, input logic lst, input logic wn,
                                input logic rdy, input int lat);
        exp_t e;
        e.rev = rev; e.flg = flg; e.cnt = cnt; e.lst = lst; e.wn = wn;
        e.rdy = rdy; e.lat = lat; e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: compare the board at every done pulse against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
                end else begin
                    me = sb.pop_front();
                    chk("latency",    64'(cyc - me.acc_cyc), 64'(me.lat));
                    chk("revealed",   revealed, me.rev);
                    chk("flagged",    flagged, me.flg);
                    chk("reveal_cnt", 64'(reveal_cnt), 64'(me.cnt));
                    chk("lost",       64'(lost), 64'(me.lst));
                    chk("won",        64'(won), 64'(me.wn));
                    chk("cmd_ready",  64'(cmd_ready), 64'(me.rdy));
                end
            end
        end
    end

    task automatic issue(input logic f, input int x, input int y, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=cmd_ready_low required=cmd_ready_high");
            return;
        end
        cmd_valid = 1'b1;
        flag      = f;
        pos_x     = 3'(x);
        pos_y     = 3'(y);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        e.acc_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_revealed"}, revealed, 64'd0);
        chk({tag, "_flagged"},  flagged, 64'd0);
        chk({tag, "_cnt"},      64'(reveal_cnt), 64'd0);
        chk({tag, "_done"},     64'(done), 64'd0);
        chk({tag, "_lost"},     64'(lost), 64'd0);
        chk({tag, "_won"},      64'(won), 64'd0);
        chk({tag, "_busy"},     64'(busy), 64'd0);
        chk({tag, "_ready"},    64'(cmd_ready), 64'd1);
    endtask

    // Hold a command that must be ignored for a few cycles.
    task automatic hold_ignored(input logic f, input int x, input int y, input int n);
        @(negedge clk);
        cmd_valid = 1'b1;
        flag      = f;
        pos_x     = 3'(x);
        pos_y     = 3'(y);
        repeat (n) @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        mine_map = 64'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Flag toggling and reveal of a flagged cell
        issue(1'b1, 2, 2, mk(64'd0, 64'd1 << 18, 7'd0, 1'b0, 1'b0, 1'b1, 0));
        drain();
        issue(1'b1, 2, 2, mk(64'd0, 64'd0, 7'd0, 1'b0, 1'b0, 1'b1, 0));
        drain();
        issue(1'b1, 2, 2, mk(64'd0, 64'd1 << 18, 7'd0, 1'b0, 1'b0, 1'b1, 0));
        drain();
        issue(1'b0, 2, 2, mk(64'd0, 64'd1 << 18, 7'd0, 1'b0, 1'b0, 1'b1, 0));
        drain();

        // Single mine at (0,0); reveal (1,1), no-ops on it, then flood to a win
        do_reset();
        mine_map = 64'd1;
        issue(1'b0, 1, 1, mk(64'd1 << 9, 64'd0, 7'd1, 1'b0, 1'b0, 1'b1, 2));
        drain();
        issue(1'b1, 1, 1, mk(64'd1 << 9, 64'd0, 7'd1, 1'b0, 1'b0, 1'b1, 0));
        drain();
        issue(1'b0, 1, 1, mk(64'd1 << 9, 64'd0, 7'd1, 1'b0, 1'b0, 1'b1, 0));
        drain();
        issue(1'b0, 7, 7, mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 7'd63, 1'b0, 1'b1, 1'b0, 543));
        drain();
        hold_ignored(1'b1, 0, 0, 3);
        repeat (2) @(negedge clk);
        chk("won_ignore_flagged",  flagged, 64'd0);
        chk("won_ignore_revealed", revealed, 64'hFFFF_FFFF_FFFF_FFFE);

        // Mine hit at (4,3)
        do_reset();
        mine_map = 64'd1 << 28;
        issue(1'b0, 4, 3, mk(64'd1 << 28, 64'd0, 7'd0, 1'b1, 1'b0, 1'b0, 0));
        drain();
        hold_ignored(1'b0, 0, 0, 3);
        repeat (2) @(negedge clk);
        chk("lost_ignore_revealed", revealed, 64'd1 << 28);
        chk("lost_ignore_cnt",      64'(reveal_cnt), 64'd0);

        // Mine row 3; commands held while busy are ignored
        do_reset();
        mine_map = 64'h0000_0000_FF00_0000;
        issue(1'b0, 0, 0, mk(64'h0000_0000_00FF_FFFF, 64'd0, 7'd24, 1'b0, 1'b0, 1'b1, 153));
        chk("busy_during_flood", 64'(busy), 64'd1);
        hold_ignored(1'b1, 7, 7, 5);
        drain();

        // Empty board: reset mid-expand, then a full rerun to a win
        do_reset();
        mine_map = 64'd0;
        issue(1'b0, 3, 4, mk({64{1'b1}}, 64'd0, 7'd64, 1'b0, 1'b1, 1'b0, 577));
        repeat (30) @(posedge clk);
        #1;
        chk("busy_before_abort", 64'(busy), 64'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk_reset_outputs("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 3, 4, mk({64{1'b1}}, 64'd0, 7'd64, 1'b0, 1'b1, 1'b0, 577));
        drain();
        chk("won_busy",  64'(busy), 64'd0);
        chk("won_ready", 64'(cmd_ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
